// File: rtl/waveform_pkg.sv
// Constants and enums shared by the waveform packetizer and formatter.
package waveform_pkg;

  localparam logic [31:0] WFRM_CMD  = 32'h5757_4441;
  localparam int unsigned HDR_WORDS = 5;

  typedef enum logic [2:0] {
    HdrCmd  = 3'd0,
    HdrId   = 3'd1,
    HdrIdx  = 3'd2,
    HdrLen  = 3'd3,
    HdrRsvd = 3'd4
  } hdr_field_e;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPayload,
    StFlush
  } wf_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register; reloads whenever empty or being drained.
module axis_out_reg #(
  parameter int unsigned DataW = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  input  logic [DataW-1:0]   in_data_i,
  input  logic               in_last_i,
  output logic               can_load_o,
  output logic               out_valid_o,
  output logic [DataW-1:0]   out_data_o,
  output logic               out_last_o,
  output logic [DataW/8-1:0] out_keep_o,
  input  logic               out_ready_i
);

  logic               valid_q, valid_d;
  logic [DataW-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic [DataW/8-1:0] keep_q, keep_d;

  assign can_load_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    keep_d  = keep_q;
    if (can_load_o) begin
      valid_d = in_valid_i;
      data_d  = in_data_i;
      last_d  = in_valid_i && in_last_i;
      keep_d  = in_valid_i ? '1 : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_keep_o  = keep_q;

endmodule

// File: rtl/waveform_packetizer.sv
// Frames a raw sample stream into headered packets (5 header words + payload slice).
module waveform_packetizer
  import waveform_pkg::*;
#(
  parameter int unsigned PKT_WORDS = 256,
  parameter logic [31:0] WFRM_CMD  = waveform_pkg::WFRM_CMD
) (
  input  logic        axi_tclk,
  input  logic        axi_tresetn,
  input  logic        start,
  input  logic [31:0] wf_id,
  input  logic [31:0] wf_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  input  logic        m_axis_tready
);

  localparam int unsigned PldWords = PKT_WORDS - HDR_WORDS;
  localparam int unsigned SW       = $clog2(PKT_WORDS);

  wf_state_e   state_q, state_d;
  hdr_field_e  hdr_cnt_q, hdr_cnt_d;
  logic [SW-1:0] slice_cnt_q, slice_cnt_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] index_q, index_d;
  logic [31:0] id_q, id_d;
  logic [31:0] len_q, len_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        can_load;
  logic        ld_valid, ld_last;
  logic [31:0] ld_data;
  logic [31:0] hdr_word;
  logic        slice_end, final_slice, accept;

  always_comb begin
    unique case (hdr_cnt_q)
      HdrCmd:  hdr_word = WFRM_CMD;
      HdrId:   hdr_word = id_q;
      HdrIdx:  hdr_word = index_q;
      HdrLen:  hdr_word = len_q;
      HdrRsvd: hdr_word = '0;
      default: hdr_word = '0;
    endcase
  end

  assign s_axis_tready = (state_q == StPayload) && can_load;
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign slice_end     = (remaining_q == 32'd1) || (slice_cnt_q == SW'(PldWords - 1));
  // Final slice: everything still owed fits in the room left in this packet.
  assign final_slice   = remaining_q <= (32'(PldWords) - 32'(slice_cnt_q));

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    slice_cnt_d = slice_cnt_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    id_d        = id_q;
    len_d       = len_q;
    err_d       = err_q;
    done_d      = 1'b0;
    ld_valid    = 1'b0;
    ld_data     = '0;
    ld_last     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (wf_len == 32'd0) begin
            done_d = 1'b1;
          end else begin
            // Output register is always empty in idle, so word 0 loads immediately.
            id_d        = wf_id;
            len_d       = wf_len;
            err_d       = 1'b0;
            index_d     = '0;
            remaining_d = wf_len;
            slice_cnt_d = '0;
            ld_valid    = 1'b1;
            ld_data     = WFRM_CMD;
            hdr_cnt_d   = HdrId;
            state_d     = StHdr;
          end
        end
      end
      StHdr: begin
        if (can_load) begin
          ld_valid = 1'b1;
          ld_data  = hdr_word;
          if (hdr_cnt_q == HdrRsvd) begin
            hdr_cnt_d = HdrCmd;
            state_d   = StPayload;
          end else begin
            hdr_cnt_d = hdr_field_e'(hdr_cnt_q + 3'd1);
          end
        end
      end
      StPayload: begin
        if (accept) begin
          ld_valid    = 1'b1;
          ld_data     = s_axis_tdata;
          remaining_d = remaining_q - 32'd1;
          slice_cnt_d = slice_cnt_q + SW'(1);
          if (slice_end) begin
            ld_last     = 1'b1;
            slice_cnt_d = '0;
            if (remaining_q == 32'd1) begin
              state_d = StFlush;
            end else begin
              index_d = index_q + 32'd1;
              state_d = StHdr;
            end
          end else if (s_axis_tlast && !final_slice) begin
            ld_last = 1'b1;
            err_d   = 1'b1;
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (can_load) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state_q     <= StIdle;
      hdr_cnt_q   <= HdrCmd;
      slice_cnt_q <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      id_q        <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      id_q        <= id_d;
      len_q       <= len_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  axis_out_reg #(
    .DataW(32)
  ) u_out_reg (
    .clk_i       (axi_tclk),
    .rst_ni      (axi_tresetn),
    .in_valid_i  (ld_valid),
    .in_data_i   (ld_data),
    .in_last_i   (ld_last),
    .can_load_o  (can_load),
    .out_valid_o (m_axis_tvalid),
    .out_data_o  (m_axis_tdata),
    .out_last_o  (m_axis_tlast),
    .out_keep_o  (m_axis_tkeep),
    .out_ready_i (m_axis_tready)
  );

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_waveform_packetizer.sv
// Randomized bench for waveform_packetizer against a packet-level reference model.
module tb_waveform_packetizer;

  localparam int Pkt = 256;
  localparam int Pld = Pkt - 5;
  localparam logic [31:0] Cmd = 32'h5757_4441;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] wf_id, wf_len;
  logic        busy, done, err;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_last, m_ready;
  logic [3:0]  m_keep;

  always #5 clk = ~clk;

  waveform_packetizer #(
    .PKT_WORDS(Pkt)
  ) dut (
    .axi_tclk      (clk),
    .axi_tresetn   (rst_n),
    .start         (start),
    .wf_id         (wf_id),
    .wf_len        (wf_len),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_last),
    .m_axis_tkeep  (m_keep),
    .m_axis_tready (m_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected {tlast, tdata} words built packet by packet.
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  bit          exp_err;

  function automatic void build_model(input logic [31:0] id, input int len,
                                      input logic [31:0] base, input int tl);
    int sent = 0;
    int n;
    int w;
    bit early;
    logic [31:0] idx = 0;
    exp_q.delete();
    exp_err = 1'b0;
    while (sent < len) begin
      exp_q.push_back({1'b0, Cmd});
      exp_q.push_back({1'b0, id});
      exp_q.push_back({1'b0, idx});
      exp_q.push_back({1'b0, 32'(len)});
      exp_q.push_back({1'b0, 32'h0});
      n = (len - sent < Pld) ? len - sent : Pld;
      for (int k = 0; k < n; k++) begin
        w = sent + k;
        early = (w == tl) && (k != n - 1) && (len - sent > Pld);
        exp_q.push_back({(k == n - 1) || early, base + 32'(w)});
        if (early) begin
          exp_err = 1'b1;
          return;
        end
      end
      sent += n;
      idx++;
    end
  endfunction

  // Source driver: ramp from src_base, optional tlast at src_tlast, optional gaps.
  int          src_len = 0;
  int          src_tlast = -1;
  int          src_epoch = 0;
  logic [31:0] src_base = '0;
  bit          rnd = 1'b0;

  initial begin : driver
    int src_idx = 0;
    int seen_epoch = 0;
    bit s_hs;
    forever begin
      @(negedge clk);
      s_hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (s_hs) src_idx++;
      if (src_epoch != seen_epoch) begin
        seen_epoch = src_epoch;
        src_idx = 0;
      end
      s_valid = (src_idx < src_len) && (!rnd || ($urandom_range(0, 1) == 1));
      s_data  = src_base + 32'(src_idx);
      s_last  = (src_idx == src_tlast);
      m_ready = !rnd || ($urandom_range(0, 1) == 1);
    end
  end

  // Output monitor: collects handshaken words and checks hold-on-stall.
  int          done_cnt = 0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pv && !pr) begin
          check("stall_valid", 64'(m_valid), 64'd1);
          check("stall_word", {m_last, m_data}, {pl, pd});
        end
        if (m_valid) check("keep", 64'(m_keep), 64'hf);
        if (m_valid && m_ready) got_q.push_back({m_last, m_data});
        if (done) done_cnt++;
      end
      pv = rst_n && m_valid;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
    end
  end

  task automatic launch(input logic [31:0] id, input int len, input int tl, input bit random);
    src_base  = $urandom;
    src_len   = len;
    src_tlast = tl;
    rnd       = random;
    src_epoch++;
    build_model(id, len, src_base, tl);
    got_q.delete();
    done_cnt = 0;
    @(posedge clk);
    #2;
    wf_id  = id;
    wf_len = 32'(len);
    start  = 1'b1;
    @(posedge clk);
    #2;
    start  = 1'b0;
    wf_id  = $urandom;
    wf_len = $urandom;
  endtask

  task automatic run(input string name, input logic [31:0] id, input int len, input int tl,
                     input bit random, input bit spurious);
    int cyc = 0;
    bit seen = 1'b0;
    int n;
    int bad = 0;
    launch(id, len, tl, random);
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({name, "_hdr0"}, {m_valid, m_data}, {1'b1, Cmd});
        check({name, "_err_clr"}, 64'(err), 64'd0);
      end
      if (spurious && cyc == 8) begin
        wf_id  = 32'd99;
        wf_len = 32'd3;
        start  = 1'b1;
      end
      if (spurious && cyc == 9) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
      end
    end
    if (!seen) check({name, "_done_timeout"}, 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    check({name, "_words"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n && bad < 20; i++) begin
      if (got_q[i] !== exp_q[i]) bad++;
      check($sformatf("%s_w%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, "_err"}, 64'(err), 64'(exp_err));
    if (!random && !spurious) check({name, "_cycles"}, 64'(cyc), 64'(exp_q.size() + 1));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tvalid"}, 64'(m_valid), 64'd0);
    check({name, "_tlast"}, 64'(m_last), 64'd0);
    check({name, "_tdata"}, 64'(m_data), 64'd0);
    check({name, "_tkeep"}, 64'(m_keep), 64'd0);
    check({name, "_tready"}, 64'(s_ready), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int waited;
    rst_n   = 1'b0;
    start   = 1'b0;
    wf_id   = '0;
    wf_len  = '0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    #1;
    rst_n = 1'b1;

    run("len1004", 32'd7, 1004, -1, 1'b0, 1'b0);
    run("len1005", 32'd7, 1005, -1, 1'b0, 1'b0);
    run("len1005_rnd", 32'h1234_5678, 1005, -1, 1'b1, 1'b0);
    run("len700_rnd", $urandom, 700, -1, 1'b1, 1'b0);

    // Zero-length start: done one cycle later, nothing emitted.
    @(posedge clk);
    #2;
    wf_len = 32'd0;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start  = 1'b0;
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_tvalid", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("zero_done_end", 64'(done), 64'd0);
    check("zero_tvalid2", 64'(m_valid), 64'd0);

    run("spurious", 32'd21, 20, -1, 1'b0, 1'b1);

    // Early input tlast on payload word 300 (index 299) truncates packet 1.
    run("early_tlast", 32'd3, 600, 299, 1'b0, 1'b0);
    check("early_err_sticky", 64'(err), 64'd1);
    check("early_idle", 64'(busy), 64'd0);
    run("after_err", 32'd4, 30, -1, 1'b1, 1'b0);

    // Reset during packet 2 payload, then a clean short waveform.
    launch(32'd9, 1004, -1, 1'b0);
    waited = 0;
    while (got_q.size() < 2 * Pkt + 5 + 20 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("rst_reach_pkt2", 64'(got_q.size() >= 2 * Pkt + 5 + 20), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_resume", 64'(m_valid), 64'd0);
    end
    run("post_rst", 32'd5, 10, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
